// File: rtl/bitonic_out_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bitonic_out_serializer_pkg
// Shared constants, FSM state encoding and the beat-to-index helper used by
// the bitonic output serializer and its order checker.
// -----------------------------------------------------------------------------
package bitonic_out_serializer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NUM_ELEM  = 8;
    localparam int IDX_W     = 3;

    localparam logic [IDX_W-1:0] FIRST_BEAT = 3'd0;
    localparam logic [IDX_W-1:0] LAST_BEAT  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Element index presented on beat k: ascending for dir=0, descending for dir=1.
    function automatic logic [IDX_W-1:0] beat_to_index(
        input logic [IDX_W-1:0] beat,
        input logic             dir
    );
        logic [IDX_W-1:0] idx;
        if (dir) begin
            idx = LAST_BEAT - beat;
        end else begin
            idx = beat;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bitonic_out_serializer_checker.sv
// -----------------------------------------------------------------------------
// bitonic_order_checker
// Watches accepted beats of one vector and raises a sticky flag when the
// stream is not monotonic in the selected direction (unsigned compare,
// equal values allowed). Beat 0 of each vector is never compared, so there
// is no comparison across vector boundaries.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   i_accept     a beat is accepted this cycle (valid && ready)
//   i_first      the accepted beat is beat 0 of its vector
//   i_dir        0 = ascending expected, 1 = descending expected
//   i_data       data of the accepted beat
//   i_err_clr    clears the sticky flag (a simultaneous violation wins)
//   o_sort_err   sticky order-violation flag (registered)
// -----------------------------------------------------------------------------
module bitonic_order_checker
    import bitonic_out_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_first,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_err_clr,
    output logic             o_sort_err
);

    logic [WIDTH-1:0] r_prev;
    logic             r_sort_err;
    logic             w_violation;

    // Direction-dependent compare of the accepted beat against the previous one.
    always_comb begin
        w_violation = 1'b0;
        if (i_accept && !i_first) begin
            if (i_dir) begin
                w_violation = (i_data > r_prev);
            end else begin
                w_violation = (i_data < r_prev);
            end
        end else begin
            w_violation = 1'b0;
        end
    end

    // Remember the last accepted value of the current vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= {WIDTH{1'b0}};
        end else if (i_accept) begin
            r_prev <= i_data;
        end
    end

    // Sticky error flag; a violation takes priority over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sort_err <= 1'b0;
        end else if (w_violation) begin
            r_sort_err <= 1'b1;
        end else if (i_err_clr) begin
            r_sort_err <= 1'b0;
        end
    end

    assign o_sort_err = r_sort_err;

endmodule

// File: rtl/bitonic_out_serializer.sv
// -----------------------------------------------------------------------------
// bitonic_out_serializer
// Captures one sorted 8-element vector through a valid/ready handshake and
// drains it one element per beat with valid/ready and a last flag. Emission
// order (ascending or descending index) is latched with each vector. The
// final beat's acceptance can overlap the next load, so back-to-back vectors
// stream without a bubble.
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   in_valid / in_ready     parallel vector handshake
//   in_dir                  emission order, sampled with the vector
//   number_in1..number_in8  sorted vector, number_in1 expected smallest
//   out_valid / out_ready   serial beat handshake
//   out_data, out_index     current element and its original index
//   out_last                current beat is the 8th of the vector
//   err_clr, sort_err       clear / sticky order-violation flag
// -----------------------------------------------------------------------------
module bitonic_out_serializer
    import bitonic_out_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [WIDTH-1:0] number_in1,
    input  logic [WIDTH-1:0] number_in2,
    input  logic [WIDTH-1:0] number_in3,
    input  logic [WIDTH-1:0] number_in4,
    input  logic [WIDTH-1:0] number_in5,
    input  logic [WIDTH-1:0] number_in6,
    input  logic [WIDTH-1:0] number_in7,
    input  logic [WIDTH-1:0] number_in8,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    input  logic             err_clr,
    output logic             sort_err
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_buf [NUM_ELEM];
    logic [IDX_W-1:0] r_cnt;
    logic             r_dir;

    logic             w_send;
    logic             w_accept;
    logic             w_final;
    logic             w_load;
    logic [IDX_W-1:0] w_idx;

    assign w_send   = (r_state == ST_SEND);
    assign w_accept = w_send && out_ready;
    assign w_final  = w_accept && (r_cnt == LAST_BEAT);
    assign w_load   = in_valid && in_ready;
    assign w_idx    = beat_to_index(r_cnt, r_dir);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a final beat with a waiting vector stays in SEND.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = ST_SEND;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_final && !in_valid) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; in_ready also opens on the accepted final beat (out_ready path).
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
                in_ready  = 1'b1;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_last  = (r_cnt == LAST_BEAT);
                in_ready  = w_final;
            end
            default: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
    end

    // Vector buffer, direction latch and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_buf[i] <= {WIDTH{1'b0}};
            end
            r_cnt <= FIRST_BEAT;
            r_dir <= 1'b0;
        end else if (w_load) begin
            r_buf[0] <= number_in1;
            r_buf[1] <= number_in2;
            r_buf[2] <= number_in3;
            r_buf[3] <= number_in4;
            r_buf[4] <= number_in5;
            r_buf[5] <= number_in6;
            r_buf[6] <= number_in7;
            r_buf[7] <= number_in8;
            r_dir    <= in_dir;
            r_cnt    <= FIRST_BEAT;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Data and index are derived purely from registered state.
    assign out_index = w_idx;
    assign out_data  = r_buf[w_idx];

    bitonic_order_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clk        (clk),
        .reset      (reset),
        .i_accept   (w_accept),
        .i_first    (r_cnt == FIRST_BEAT),
        .i_dir      (r_dir),
        .i_data     (out_data),
        .i_err_clr  (err_clr),
        .o_sort_err (sort_err)
    );

endmodule

// File: tb/tb_bitonic_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_bitonic_out_serializer
// Directed bench: stimulus pushes expected beats into a scoreboard queue,
// an independent monitor pops and compares on every accepted output beat.
// -----------------------------------------------------------------------------
module tb_bitonic_out_serializer;

    typedef logic [7:0][7:0] vec_t;   // element k = number_in(k+1)
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_dir;
    logic [7:0] number_in1, number_in2, number_in3, number_in4;
    logic [7:0] number_in5, number_in6, number_in7, number_in8;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_index;
    logic       out_last;
    logic       err_clr;
    logic       sort_err;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    bitonic_out_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dir     (in_dir),
        .number_in1 (number_in1),
        .number_in2 (number_in2),
        .number_in3 (number_in3),
        .number_in4 (number_in4),
        .number_in5 (number_in5),
        .number_in6 (number_in6),
        .number_in7 (number_in7),
        .number_in8 (number_in8),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .err_clr    (err_clr),
        .sort_err   (sort_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input vec_t v);
        number_in1 = v[0]; number_in2 = v[1]; number_in3 = v[2]; number_in4 = v[3];
        number_in5 = v[4]; number_in6 = v[5]; number_in7 = v[6]; number_in8 = v[7];
    endtask

    // Offer a vector, wait for in_ready, queue its expected beats, complete the handshake.
    task automatic load(input vec_t v, input logic d, output logic hs_last);
        int budget;
        beat_t b;
        budget = 0;
        drive_vec(v);
        in_dir   = d;
        in_valid = 1'b1;
        while (!in_ready && budget < 30) begin
            step();
            budget++;
        end
        chk("load_in_ready", {31'd0, in_ready}, 32'd1);
        hs_last = out_last;
        for (int k = 0; k < 8; k++) begin
            b.idx  = d ? 3'(7 - k) : 3'(k);
            b.data = v[b.idx];
            b.last = (k == 7);
            sb_q.push_back(b);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((sb_q.size() != 0 || out_valid) && budget < 60) begin
            step();
            budget++;
        end
        chk("drain_timeout", {31'd0, (budget < 60)}, 32'd1);
    endtask

    // Scoreboard monitor: compare every accepted beat against the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("beat_data",  {24'd0, out_data},  {24'd0, e.data});
                chk("beat_index", {29'd0, out_index}, {29'd0, e.idx});
                chk("beat_last",  {31'd0, out_last},  {31'd0, e.last});
            end
        end
    end

    initial begin
        vec_t v_sorted, v_zero1, v_bad, v_junk;
        logic hs;
        v_sorted = {8'd255, 8'd41, 8'd40, 8'd33, 8'd20, 8'd12, 8'd7, 8'd3};
        v_zero1  = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        v_bad    = {8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd5};
        v_junk   = {8'd99, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94, 8'd93, 8'd92};

        reset = 1'b1; in_valid = 1'b0; in_dir = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        drive_vec(v_junk);
        repeat (2) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_index", {29'd0, out_index}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_sort_err",  {31'd0, sort_err},  32'd0);
        reset = 1'b0;
        step();

        // 1: ascending emission, one-cycle load latency
        load(v_sorted, 1'b0, hs);
        chk("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        wait_idle();
        chk("t1_sort_err", {31'd0, sort_err}, 32'd0);
        chk("t1_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // 2: descending emission
        load(v_sorted, 1'b1, hs);
        wait_idle();
        chk("t2_sort_err", {31'd0, sort_err}, 32'd0);

        // 3: backpressure on beat 2, ignored mid-stream load attempt
        load(v_sorted, 1'b0, hs);
        step();
        step();
        out_ready = 1'b0;
        drive_vec(v_junk);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_data",  {24'd0, out_data},  32'd12);
            chk("t3_hold_index", {29'd0, out_index}, 32'd2);
            chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();
        chk("t3_sort_err", {31'd0, sort_err}, 32'd0);

        // 4: back-to-back, second vector loads during first vector's last beat
        load(v_sorted, 1'b0, hs);
        load(v_zero1, 1'b0, hs);
        chk("t4_overlap_last", {31'd0, hs}, 32'd1);
        chk("t4_no_gap_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_no_gap_index", {29'd0, out_index}, 32'd0);
        wait_idle();
        chk("t4_sort_err", {31'd0, sort_err}, 32'd0);

        // 5: unsorted vector sets sticky error; clear; set wins over clear
        load(v_bad, 1'b0, hs);
        chk("t5_err_before", {31'd0, sort_err}, 32'd0);
        step();
        step();
        chk("t5_err_set", {31'd0, sort_err}, 32'd1);
        wait_idle();
        chk("t5_err_sticky", {31'd0, sort_err}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t5_err_cleared", {31'd0, sort_err}, 32'd0);
        load(v_bad, 1'b0, hs);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t5_set_wins", {31'd0, sort_err}, 32'd1);
        wait_idle();

        // 6: asynchronous reset during beat 4
        load(v_sorted, 1'b0, hs);
        repeat (4) step();
        chk("t6_at_beat4", {29'd0, out_index}, 32'd4);
        reset = 1'b1;
        #1;
        sb_q.delete();
        chk("t6_rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready},  32'd1);
        chk("t6_rst_sort_err", {31'd0, sort_err},  32'd0);
        step();
        reset = 1'b0;
        step();
        load(v_sorted, 1'b1, hs);
        chk("t6_restart_index", {29'd0, out_index}, 32'd7);
        wait_idle();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
